tick_gen: RTL and testbench

Parametrised multi-channel clock-enable generator; next generation of the fixed counter-tap divider. Each channel produces a single-cycle `tick` enable and a 50 % duty square wave, with a runtime-programmable divide ratio. Consumers (game logic, movement, VGA pixel enable, 7-segment scan) run on `clk` and qualify their logic with `tick`. They no longer use derived clocks.

---
 rtl/tick_gen_pkg.sv | 14 +
 rtl/tick_chan.sv | 88 ++++++++
 rtl/tick_gen.sv | 60 ++++++
 tb/tb_tick_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and types for the tick_gen clock-enable block.
//   NUM_CH_DEF      default channel count
//   DIV_W_DEF       default divisor / counter width
//   DEFAULT_DIV_DEF divisor loaded into every channel at reset
//   div_t           divisor type at the default width
package tick_gen_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int DIV_W_DEF       = 26;
  localparam int DEFAULT_DIV_DEF = 4;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one clock-enable channel. Counts enabled cycles up to div_act-1,
// emits a one-cycle tick at the wrap and toggles sq on every tick.
// A divisor written while running is parked in a shadow register and
// applied at the next tick so no period is ever cut short.
//   clk, rst_n  clock, synchronous active-low reset
//   en          run enable
//   resync      restart phase (cnt/tick/sq cleared, shadow applied)
//   wr, wr_div  accepted divisor write for this channel
//   tick, sq    registered enable pulse and square wave
//   pend        shadow divisor waiting for a tick boundary
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             resync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [DIV_W-1:0] cnt, div_act, div_shd;
  logic             running, wrap;

  assign running = en && (div_act != '0);
  assign wrap    = (cnt == div_act - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= DIV_W'(DEFAULT_DIV);
      div_shd <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else if (resync) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      pend <= 1'b0;
      if (wr)        div_act <= wr_div;
      else if (pend) div_act <= div_shd;
    end else if (!running) begin
      tick <= 1'b0;
      // off: force the outputs quiet; held: cnt and sq keep their value
      if (div_act == '0) begin
        cnt <= '0;
        sq  <= 1'b0;
      end
      // New divisor lands directly; cnt restarts so the next enabled edge
      // is cycle 1 of the new period and cnt stays below div_act.
      if (wr) begin
        div_act <= wr_div;
        cnt     <= '0;
      end else if (pend) begin
        div_act <= div_shd;
        pend    <= 1'b0;
        cnt     <= '0;
      end
    end else begin
      if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
        if (pend) begin
          div_act <= div_shd;
          pend    <= 1'b0;
        end
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
      // wr only happens with pend clear, so this never collides with the
      // shadow apply above
      if (wr) begin
        div_shd <= wr_div;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel clock-enable generator.
//   clk, rst_n         clock, synchronous active-low reset
//   ch_en[NUM_CH]      per-channel run enable
//   resync             one-cycle pulse, phase-aligns all channels
//   cfg_valid/ready    divisor write handshake (ready = target not pending)
//   cfg_ch, cfg_div    target channel and new divisor (0 = off)
//   tick[NUM_CH]       single-cycle enable per channel
//   sq[NUM_CH]         50 % square wave per channel
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int  NUM_CH      = NUM_CH_DEF,
  parameter int  DIV_W       = DIV_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [NUM_CH-1:0] pend, wr;

  // Out-of-range channels match nothing: ready stays 1 and the write drops.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend[i];
        wr[i]     = cfg_valid && !pend[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ch_en[i]),
      .resync (resync),
      .wr     (wr[i]),
      .wr_div (cfg_div),
      .tick   (tick[i]),
      .sq     (sq[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 26;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              resync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  always #5 clk = ~clk;

  tick_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .resync    (resync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq)
  );

  typedef struct {
    logic             rst_n;
    logic [3:0]       en;
    logic             rs;
    logic             cv;
    logic [1:0]       ch;
    logic [DIV_W-1:0] div;
    logic             chk_rdy;
    logic             erdy;
    logic [3:0]       et;
    logic [3:0]       es;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic [3:0] en, input logic rs, input logic cv,
                     input logic [1:0] ch, input int div, input logic chk, input logic erdy,
                     input logic [3:0] et, input logic [3:0] es);
    vec_t v;
    v.rst_n = r; v.en = en; v.rs = rs; v.cv = cv; v.ch = ch; v.div = DIV_W'(div);
    v.chk_rdy = chk; v.erdy = erdy; v.et = et; v.es = es;
    vq.push_back(v);
  endtask

  task automatic run(input logic [3:0] en, input logic [3:0] et, input logic [3:0] es);
    add(1, en, 0, 0, 0, 0, 0, 0, et, es);
  endtask

  task automatic rst2();
    add(0, 4'h0, 0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b, want %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = '0; resync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

    // A: all channels at the reset divisor 4
    rst2();
    for (int e = 1; e <= 12; e++)
      run(4'hF, (e % 4 == 0) ? 4'hF : 4'h0, ((e / 4) % 2 == 1) ? 4'hF : 4'h0);

    // B: ch0 running D=4, write D=2 at edge 2; ready low until tick at 4
    rst2();
    run(4'h1, 4'h0, 4'h0);
    add(1, 4'h1, 0, 1, 0, 2, 1, 1, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 0, 1, 0, 4'h1, 4'h1);
    add(1, 4'h1, 0, 0, 0, 0, 1, 1, 4'h0, 4'h1);
    run(4'h1, 4'h1, 4'h0);
    run(4'h1, 4'h0, 4'h0);
    run(4'h1, 4'h1, 4'h1);

    // C: ch1 to D=0 (pending until its tick), then D=3 while off
    rst2();
    run(4'hF, 4'h0, 4'h0);
    add(1, 4'hF, 0, 1, 1, 0, 1, 1, 4'h0, 4'h0);
    add(1, 4'hF, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0);
    run(4'hF, 4'hF, 4'hF);
    run(4'hF, 4'h0, 4'hD);
    run(4'hF, 4'h0, 4'hD);
    add(1, 4'hF, 0, 1, 1, 3, 1, 1, 4'h0, 4'hD);
    run(4'hF, 4'hD, 4'h0);
    run(4'hF, 4'h0, 4'h0);
    run(4'hF, 4'h2, 4'h2);
    run(4'hF, 4'h0, 4'h2);
    run(4'hF, 4'hD, 4'hF);
    run(4'hF, 4'h2, 4'hD);

    // D: ch0 D=3, ch1 D=5 (written while held), run, resync, rerun
    rst2();
    add(1, 4'h0, 0, 1, 0, 3, 1, 1, 4'h0, 4'h0);
    add(1, 4'h0, 0, 1, 1, 5, 1, 1, 4'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      run(4'hF, 4'h0, 4'h0);
      run(4'hF, 4'h0, 4'h0);
      run(4'hF, 4'h1, 4'h1);
      run(4'hF, 4'hC, 4'hD);
      run(4'hF, 4'h2, 4'hF);
      if (k == 0) begin
        run(4'hF, 4'h1, 4'hE);
        run(4'hF, 4'h0, 4'hE);
        add(1, 4'hF, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
      end
    end

    // E: ch2 held for 10 edges after edge 6, then resumes from cnt=2
    rst2();
    for (int e = 1; e <= 6; e++)
      run(4'hF, (e == 4) ? 4'hF : 4'h0, (e >= 4) ? 4'hF : 4'h0);
    run(4'hB, 4'h0, 4'hF);
    run(4'hB, 4'hB, 4'h4);
    for (int e = 9; e <= 11; e++) run(4'hB, 4'h0, 4'h4);
    run(4'hB, 4'hB, 4'hF);
    for (int e = 13; e <= 15; e++) run(4'hB, 4'h0, 4'hF);
    run(4'hB, 4'hB, 4'h4);
    run(4'hF, 4'h0, 4'h4);
    run(4'hF, 4'h4, 4'h0);
    run(4'hF, 4'h0, 4'h0);
    run(4'hF, 4'hB, 4'hB);

    // F: ch3 D=1, then reset mid-run restores D=4
    rst2();
    add(1, 4'h0, 0, 1, 3, 1, 1, 1, 4'h0, 4'h0);
    run(4'h8, 4'h8, 4'h8);
    run(4'h8, 4'h8, 4'h0);
    run(4'h8, 4'h8, 4'h8);
    add(0, 4'h8, 0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    run(4'h8, 4'h0, 4'h0);
    run(4'h8, 4'h0, 4'h0);
    run(4'h8, 4'h0, 4'h0);
    run(4'h8, 4'h8, 4'h8);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; ch_en = vq[i].en; resync = vq[i].rs;
      cfg_valid = vq[i].cv; cfg_ch = vq[i].ch; cfg_div = vq[i].div;
      #1;
      if (vq[i].chk_rdy) chk("cfg_ready", i, {3'b0, cfg_ready}, {3'b0, vq[i].erdy});
      @(posedge clk);
      #1;
      chk("tick", i, tick, vq[i].et);
      chk("sq", i, sq, vq[i].es);
    end

    // Hand sequence: resync applies a pending shadow divisor
    @(negedge clk);
    rst_n = 1'b0; ch_en = '0; resync = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ch_en = 4'h1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = DIV_W'(2);
    #1 chk("rs_rdy0", 0, {3'b0, cfg_ready}, 4'h1);
    @(negedge clk);
    cfg_valid = 1'b0; resync = 1'b1;
    #1 chk("rs_rdy1", 1, {3'b0, cfg_ready}, 4'h0);
    @(posedge clk); #1;
    chk("rs_tick", 1, tick, 4'h0);
    chk("rs_sq", 1, sq, 4'h0);
    @(negedge clk);
    resync = 1'b0;
    #1 chk("rs_rdy2", 2, {3'b0, cfg_ready}, 4'h1);
    @(posedge clk); #1;
    chk("rs_tick", 2, tick, 4'h0);
    @(posedge clk); #1;
    chk("rs_tick", 3, tick, 4'h1);
    chk("rs_sq", 3, sq, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
